// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared types and constants for the FFT frame sequencer
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        DRAIN,
        RELEASE,
        WAIT_CLR
    } seq_state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam int BIN_RE_W   = 14;
    localparam int BIN_IM_W   = 14;
    localparam int BIN_WORD_W = BIN_RE_W + BIN_IM_W;

endpackage

// File: rtl/fft_seq_fifo.sv
// rtl/fft_seq_fifo.sv - 4-entry show-ahead FIFO for gathered bin beats
// Simultaneous push and pop is legal at any occupancy, including full.
module fft_seq_fifo
    import fft_seq_pkg::*;
#(
    parameter int WORD_W = 112,
    parameter int IDX_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WORD_W-1:0]     push_data,
    input  logic [IDX_W-1:0]      push_idx,
    input  logic                  push_sop,
    input  logic                  push_eop,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [WORD_W-1:0]     head_data,
    output logic [IDX_W-1:0]      head_idx,
    output logic                  head_sop,
    output logic                  head_eop,
    output logic [FIFO_CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [IDX_W-1:0]  mem_idx  [FIFO_DEPTH];
    logic              mem_sop  [FIFO_DEPTH];
    logic              mem_eop  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    assign do_pop = pop && head_valid;

    // Storage is reset too so the head fields read as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
                mem_sop[i]  <= 1'b0;
                mem_eop[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_idx[wr_ptr]  <= push_idx;
                mem_sop[wr_ptr]  <= push_sop;
                mem_eop[wr_ptr]  <= push_eop;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem_data[rd_ptr];
    assign head_idx   = mem_idx[rd_ptr];
    assign head_sop   = mem_sop[rd_ptr];
    assign head_eop   = mem_eop[rd_ptr];

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - reads all channel FFT RAMs in lockstep and streams per-bin vectors
// FFT_SEQ_HALF_SPECTRUM_EN: when defined only the lower half of the spectrum is streamed.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int FFT_PTS = 1024,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = BIN_WORD_W,
    parameter int RD_LAT  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        fft_ready,
    output logic                     fft_go,
    output logic [ADDR_W-1:0]        rd_addr_fft,
    input  logic [NUM_CH*DATA_W-1:0] ram_q_all,
    output logic                     bin_valid,
    input  logic                     bin_ready,
    output logic [NUM_CH*DATA_W-1:0] bin_data,
    output logic [ADDR_W-1:0]        bin_idx,
    output logic                     bin_sop,
    output logic                     bin_eop,
    output logic                     seq_err
);

`ifdef FFT_SEQ_HALF_SPECTRUM_EN
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_PTS / 2 - 1);
`else
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_PTS - 1);
`endif

    seq_state_t state;
    seq_state_t state_nxt;

    logic                  all_ready;
    logic                  none_ready;
    logic                  stream_entry;
    logic                  issue;
    logic                  credit_ok;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W-1:0] inflight;

    logic              dl_valid [RD_LAT];
    logic [ADDR_W-1:0] dl_idx   [RD_LAT];
    logic              dl_sop   [RD_LAT];
    logic              dl_eop   [RD_LAT];

    assign all_ready    = &fft_ready;
    assign none_ready   = ~|fft_ready;
    assign stream_entry = (state == IDLE) && all_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + FIFO_CNT_W'(dl_valid[i]);
        end
    end

    // Reads in flight are counted against FIFO space so a return can never overflow it.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (all_ready) state_nxt = STREAM;
            STREAM:   if (issue && (rd_addr_fft == LAST_BIN)) state_nxt = DRAIN;
            DRAIN:    if ((inflight == '0) && (fifo_count == '0)) state_nxt = RELEASE;
            RELEASE:  state_nxt = WAIT_CLR;
            WAIT_CLR: if (none_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue  = (state == STREAM) && credit_ok;
        fft_go = (state == RELEASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_fft <= '0;
        end else if (stream_entry) begin
            rd_addr_fft <= '0;
        end else if (issue && (rd_addr_fft != LAST_BIN)) begin
            rd_addr_fft <= rd_addr_fft + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_idx[i]   <= '0;
                dl_sop[i]   <= 1'b0;
                dl_eop[i]   <= 1'b0;
            end
        end else begin
            dl_valid[0] <= issue;
            dl_idx[0]   <= rd_addr_fft;
            dl_sop[0]   <= (rd_addr_fft == '0);
            dl_eop[0]   <= (rd_addr_fft == LAST_BIN);
            for (int i = 1; i < RD_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_idx[i]   <= dl_idx[i-1];
                dl_sop[i]   <= dl_sop[i-1];
                dl_eop[i]   <= dl_eop[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err <= 1'b0;
        end else if (stream_entry) begin
            seq_err <= 1'b0;
        end else if (((state == STREAM) || (state == DRAIN)) && !all_ready) begin
            seq_err <= 1'b1;
        end
    end

    fft_seq_fifo #(
        .WORD_W (NUM_CH * DATA_W),
        .IDX_W  (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (dl_valid[RD_LAT-1]),
        .push_data  (ram_q_all),
        .push_idx   (dl_idx[RD_LAT-1]),
        .push_sop   (dl_sop[RD_LAT-1]),
        .push_eop   (dl_eop[RD_LAT-1]),
        .pop        (bin_ready),
        .head_valid (bin_valid),
        .head_data  (bin_data),
        .head_idx   (bin_idx),
        .head_sop   (bin_sop),
        .head_eop   (bin_eop),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - randomized self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

    localparam int NUM_CH  = 4;
    localparam int FFT_PTS = 1024;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 28;
    localparam int RD_LAT  = 2;
`ifdef FFT_SEQ_HALF_SPECTRUM_EN
    localparam int N_BINS  = FFT_PTS / 2;
`else
    localparam int N_BINS  = FFT_PTS;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        fft_ready;
    logic                     fft_go;
    logic [ADDR_W-1:0]        rd_addr_fft;
    logic [NUM_CH*DATA_W-1:0] ram_q_all;
    logic                     bin_valid;
    logic                     bin_ready = 1'b1;
    logic [NUM_CH*DATA_W-1:0] bin_data;
    logic [ADDR_W-1:0]        bin_idx;
    logic                     bin_sop;
    logic                     bin_eop;
    logic                     seq_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] seed;
    bit          ready_mode = 1'b0;
    int          exp_idx = 0;
    int          go_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [NUM_CH*DATA_W-1:0] prev_data;
    logic [ADDR_W+1:0]        prev_meta;
    logic [ADDR_W-1:0]        ram_pipe [RD_LAT];

    always #5 clk = ~clk;

    fft_frame_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fft_ready   (fft_ready),
        .fft_go      (fft_go),
        .rd_addr_fft (rd_addr_fft),
        .ram_q_all   (ram_q_all),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .bin_data    (bin_data),
        .bin_idx     (bin_idx),
        .bin_sop     (bin_sop),
        .bin_eop     (bin_eop),
        .seq_err     (seq_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ram_word(input int ch, input int idx);
        logic [31:0] h;
        h = seed ^ (32'(ch) * 32'h9E3779B9) ^ (32'(idx) * 32'h85EBCA6B);
        h = h ^ (h >> 13);
        return h[DATA_W-1:0];
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] exp_data(input int idx);
        logic [NUM_CH*DATA_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = ram_word(c, idx);
        return v;
    endfunction

    // Channel RAM bank: address registered RD_LAT times before the word appears.
    always @(posedge clk) begin
        ram_pipe[0] <= rd_addr_fft;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end

    always_comb begin
        ram_q_all = '0;
        for (int c = 0; c < NUM_CH; c++)
            ram_q_all[c*DATA_W +: DATA_W] = ram_word(c, int'(ram_pipe[RD_LAT-1]));
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bin_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: every frame must deliver bins 0..N_BINS-1 in order, then one fft_go.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", bin_valid, 1'b1);
                check("stall_meta", {bin_idx, bin_sop, bin_eop}, prev_meta);
                check("stall_data", bin_data, prev_data);
            end
            if (bin_valid && bin_ready) begin
                check("beat_idx", bin_idx, exp_idx);
                check("beat_sop", bin_sop, exp_idx == 0);
                check("beat_eop", bin_eop, exp_idx == N_BINS - 1);
                check("beat_data", bin_data, exp_data(exp_idx));
                exp_idx++;
            end
            prev_stall = bin_valid && !bin_ready;
            prev_data  = bin_data;
            prev_meta  = {bin_idx, bin_sop, bin_eop};
            if (fft_go) begin
                go_cnt++;
                check("frame_complete", exp_idx, N_BINS);
                exp_idx = 0;
            end
        end
    end

    task automatic wait_go(input int limit);
        int t = 0;
        while (!fft_go && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("go_seen", fft_go, 1'b1);
    endtask

    initial begin
        int t;
        int bad;
        logic [ADDR_W-1:0] hold;

        seed      = $urandom;
        rst_n     = 1'b0;
        fft_ready = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {fft_go, rd_addr_fft, bin_valid, bin_idx, bin_sop, bin_eop, seq_err}, '0);
        check("reset_data", bin_data, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: full-rate drain, latency and fft_go timing.
        fft_ready = 4'hF;
        @(posedge clk);
        t = 0;
        @(negedge clk);
        while (!bin_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("first_valid_lat", t, RD_LAT + 1);
        check("first_idx", bin_idx, 0);
        check("first_sop", bin_sop, 1'b1);
        t = 0;
        while (!fft_go && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("go_latency", t, N_BINS + 1);
        check("no_err_frame1", seq_err, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bin_valid || fft_go) bad++;
        end
        check("no_retrigger", bad, 0);
        fft_ready = '0;
        repeat (3) @(negedge clk);

        // Frame 2: partial ready must not start; random backpressure; channel 2 glitch.
        hold      = rd_addr_fft;
        fft_ready = 4'h7;
        bad       = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_addr_fft != hold || bin_valid) bad++;
        end
        check("partial_ready_hold", bad, 0);
        ready_mode = 1'b1;
        fft_ready  = 4'hF;
        t = 0;
        while (rd_addr_fft != ADDR_W'(300) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reach_bin300", t < 5000, 1'b1);
        fft_ready = 4'hB;
        repeat (5) @(negedge clk);
        fft_ready = 4'hF;
        wait_go(20000);
        check("seq_err_at_go", seq_err, 1'b1);
        fft_ready = '0;
        repeat (3) @(negedge clk);
        check("seq_err_sticky", seq_err, 1'b1);

        // Frame 3: error clears on entry, asynchronous reset mid-frame restarts at bin 0.
        fft_ready = 4'hF;
        @(negedge clk);
        check("seq_err_clear", seq_err, 1'b0);
        t = 0;
        while (!(bin_valid && bin_idx == ADDR_W'(200)) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reach_beat200", t < 5000, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_ctrl", {fft_go, rd_addr_fft, bin_valid, bin_idx, bin_sop, bin_eop, seq_err}, '0);
        check("midframe_rst_data", bin_data, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_go(20000);
        @(negedge clk);
        check("go_count", go_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Frame-level controller for the per-channel FFT wrappers. It waits until every channel's FFT result RAM reports ready, then drives one shared read address into all channel RAMs. The gathered per-bin channel vectors are streamed downstream under valid/ready backpressure. When the frame is fully delivered, it pulses `fft_go` to re-arm all channels. It sits between the FFT wrapper bank and the localization stage (cross-spectrum/beamforming).

## Interface
- `NUM_CH`, 4: number of microphone channels / FFT wrappers.
- `FFT_PTS`, 1024: FFT points per frame (power of two).
- `ADDR_W`, 10: bin address width, equals log2(`FFT_PTS`).
- `DATA_W`, 28: one bin word, {real[13:0], imag[13:0]}.
- `RD_LAT`, 2: FFT RAM read latency in cycles, from `rd_addr_fft` to `ram_q_all`. Legal values are 1 or 2.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `fft_ready` in `NUM_CH`: per-channel `out_ready` from the FFT wrappers.
- `fft_go` out 1: one-cycle pulse that releases all wrappers for the next frame.
- `rd_addr_fft` out `ADDR_W`: shared read address to all channel RAMs.
- `ram_q_all` in `NUM_CH`*`DATA_W`: concatenated RAM outputs; channel 0 occupies the LSBs.
- `bin_valid` out 1: output beat valid.
- `bin_ready` in 1: downstream accept.
- `bin_data` out `NUM_CH`*`DATA_W`: all channels' words for one bin.
- `bin_idx` out `ADDR_W`: bin number of the current beat.
- `bin_sop` / `bin_eop` out 1: first and last beat of the frame.
- `seq_err` out 1: sticky error flag. It is set if any `fft_ready` bit drops during STREAM or DRAIN, and cleared on the next STREAM entry.

## Operation
- Reset value of every output is 0, and `rd_addr_fft` is 0. The state machine resets to IDLE and the FIFO is empty.
- IDLE: go to STREAM when `fft_ready` is all-ones.
- STREAM: issue one address per cycle while the issue credit allows it.
  - Issue credit: FIFO occupancy plus reads in flight must be less than 4.
  - `rd_addr_fft` increments by 1 only on an issue cycle and holds otherwise.
  - After issuing `LAST_BIN`, go to DRAIN.
- DRAIN: wait until reads in flight are 0 and the FIFO is empty (the last beat has been accepted), then go to RELEASE.
- RELEASE: assert `fft_go` for exactly one cycle, then go to WAIT_CLR.
- WAIT_CLR: wait until `fft_ready` is all-zeros, then go to IDLE. This prevents the stale ready level from retriggering the sequencer while the wrappers leave their READY state.
- Read-return path:
  - A delay line of `RD_LAT` stages carries valid, bin index, sop and eop.
  - `ram_q_all` is captured into a 4-entry FIFO at the cycle the matching delay-line slot emerges.
- Output is the FIFO head, show-ahead.
  - A beat transfers when `bin_valid` and `bin_ready` are both high.
  - `bin_data`, `bin_idx`, `bin_sop` and `bin_eop` hold stable while `bin_valid` is high and `bin_ready` is low.
- Push and pop in the same cycle are allowed at any occupancy, including full. The credit rule guarantees a push never meets a full FIFO without a simultaneous pop.
- `bin_sop` = (bin index == 0). `bin_eop` = (bin index == `LAST_BIN`).
- The address counter is `ADDR_W` bits and never wraps inside a frame; it is cleared to 0 on STREAM entry.

## Timing
- Transitions, with `fft_ready` all-ones sampled at edge T:
  - STREAM at T+1, first address 0 presented during cycle T+1.
  - Address k is captured into the FIFO at T+1+k+`RD_LAT`.
  - First `bin_valid` is high in cycle T+2+`RD_LAT`.
- With `bin_ready` held high: one bin per cycle, no bubbles, for `RD_LAT` ≤ 2.
- When `bin_ready` drops: issue stops within 1 cycle, the FIFO absorbs in-flight reads, and no beat is lost.
- `fft_go` fires the cycle after the DRAIN exit condition holds.
- Asynchronous reset mid-frame: the frame is discarded immediately and no `fft_go` is issued.
  - The wrappers stay in READY.
  - After reset release the sequencer re-streams that frame from bin 0.

## Configuration
- `FFT_SEQ_HALF_SPECTRUM_EN`
  - Defined: `LAST_BIN` = `FFT_PTS`/2−1 (512 beats). The upper conjugate-symmetric half of the real-input spectrum is never read.
  - Undefined: `LAST_BIN` = `FFT_PTS`−1 (1024 beats).

## Structure
- Shared package `fft_seq_pkg`:
  - State enum {IDLE, STREAM, DRAIN, RELEASE, WAIT_CLR}.
  - FIFO depth constant (4).
  - Bin-word field widths (14/14).
- One sub-module: `fft_seq_fifo`, a 4-entry show-ahead FIFO with data, bin index, sop and eop fields, plus an occupancy count output used for the issue credit.

## Test plan
- Default configuration, `bin_ready`=1, `fft_ready` 4'hF at T → first `bin_valid` at T+4 with `bin_idx`=0 and `bin_sop`=1; 1024 consecutive beats, the last with `bin_eop`=1 and `bin_idx`=1023; one `fft_go` pulse; `bin_data` matches the RAM model per channel.
- `bin_ready` toggled by an LFSR → no duplicate, dropped or reordered bins; outputs stable while stalled; FIFO never overflows.
- `fft_ready` = 4'h7 held for 100 cycles, then 4'hF → no address issue until all four are ready.
- `fft_ready` kept high for 2 cycles after `fft_go` → no second frame starts until it goes to 4'h0, then 4'hF.
- Channel 2 ready drops at bin 300 → `seq_err`=1, still sticky at frame end; cleared at the next STREAM entry.
- `FFT_SEQ_HALF_SPECTRUM_EN` defined → 512 beats, `bin_eop` at `bin_idx`=511; `rst_n` pulsed at bin 200 → all outputs 0, no `fft_go`, the next frame restarts at bin 0.
